// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, port ids, timeout read data.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOW    = 3'd1,
        ST_GAP_LO = 3'd2,
        ST_HIGH   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef enum logic {
        PORT_P0 = 1'b0,
        PORT_P1 = 1'b1
    } port_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin grant; last_grant resets to P1 so P0 wins the first tie.
// Combinational grant, 0 cycles; last_grant only moves when the grant is taken.
module sram_arb_rr2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       grant_vld,
    output port_e      grant_port
);

    port_e last_grant;

    always_comb begin
        grant_vld  = |req;
        grant_port = PORT_P0;
        if (req == 2'b11) begin
            grant_port = (last_grant == PORT_P0) ? PORT_P1 : PORT_P0;
        end else if (req[1]) begin
            grant_port = PORT_P1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_P1;
        end else if (take && grant_vld) begin
            last_grant <= grant_port;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares a 16-bit SRAM port between two 32-bit requesters; each access is low then high halfword.
// Latency 3 + T_lo + T_hi; waits on i_sram_ready (bounded by a watchdog under SRAM_ARBITER_TIMEOUT_EN).
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W         = 17,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_p0_request,
    input  logic              i_p0_rw,
    input  logic [ADDR_W-1:0] i_p0_address,
    input  logic [31:0]       i_p0_wdata,
    output logic [31:0]       o_p0_rdata,
    output logic              o_p0_ready,
    input  logic              i_p1_request,
    input  logic              i_p1_rw,
    input  logic [ADDR_W-1:0] i_p1_address,
    input  logic [31:0]       i_p1_wdata,
    output logic [31:0]       o_p1_rdata,
    output logic              o_p1_ready,
`ifdef SRAM_ARBITER_TIMEOUT_EN
    output logic              o_p0_error,
    output logic              o_p1_error,
`endif
    output logic              o_sram_enable,
    output logic              o_sram_rw,
    output logic [ADDR_W:0]   o_sram_address,
    output logic [15:0]       o_sram_wdata,
    input  logic [15:0]       i_sram_rdata,
    input  logic              i_sram_ready
);

    state_e            state_q, state_d;
    port_e             grant_port, port_q;
    logic              grant_vld, take;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q, rdata_out;
    logic              in_access, timeout;

    sram_arb_rr2 u_rr2 (
        .clk        (i_clock),
        .rst_n      (i_reset_n),
        .req        ({i_p1_request, i_p0_request}),
        .take       (take),
        .grant_vld  (grant_vld),
        .grant_port (grant_port)
    );

    assign in_access = (state_q == ST_LOW) || (state_q == ST_HIGH);

`ifdef SRAM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Counter restarts in GAP_LO, so each half gets the full watchdog budget.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= in_access ? cnt_q + 1'b1 : '0;
            err_q <= timeout;
        end
    end

    assign timeout    = in_access && !i_sram_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rdata_out  = err_q ? TIMEOUT_RDATA : rdata_q;
    assign o_p0_error = o_p0_ready && err_q;
    assign o_p1_error = o_p1_ready && err_q;
`else
    assign timeout   = 1'b0;
    assign rdata_out = rdata_q;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        take          = 1'b0;
        o_sram_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    take    = 1'b1;
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                o_sram_enable = 1'b1;
                if (i_sram_ready) begin
                    state_d = ST_GAP_LO;
                end else if (timeout) begin
                    state_d = ST_DONE;
                end
            end
            // One enable-low cycle lets the downstream sequencer see a fresh request.
            ST_GAP_LO: state_d = ST_HIGH;
            ST_HIGH: begin
                o_sram_enable = 1'b1;
                if (i_sram_ready || timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            port_q  <= PORT_P0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (take) begin
                port_q <= grant_port;
                if (grant_port == PORT_P1) begin
                    rw_q    <= i_p1_rw;
                    addr_q  <= i_p1_address;
                    wdata_q <= i_p1_wdata;
                end else begin
                    rw_q    <= i_p0_rw;
                    addr_q  <= i_p0_address;
                    wdata_q <= i_p0_wdata;
                end
            end
            if (i_sram_ready && !rw_q) begin
                if (state_q == ST_LOW) begin
                    rdata_q[15:0] <= i_sram_rdata;
                end
                if (state_q == ST_HIGH) begin
                    rdata_q[31:16] <= i_sram_rdata;
                end
            end
        end
    end

    // Halfword select is the LSB; the word address never carries into it.
    assign o_sram_rw      = rw_q;
    assign o_sram_address = {addr_q, state_q == ST_HIGH};
    assign o_sram_wdata   = (state_q == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0];

    assign o_p0_ready = (state_q == ST_DONE) && (port_q == PORT_P0);
    assign o_p1_ready = (state_q == ST_DONE) && (port_q == PORT_P1);
    assign o_p0_rdata = o_p0_ready ? rdata_out : '0;
    assign o_p1_rdata = o_p1_ready ? rdata_out : '0;

endmodule
